memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// - Shares the single-ported RAM between instruction fetch (IF) and data access (MEM) of the pipelined datapath.
// - Sits between datapath_cache_if request signals and the RAM.
// - Sequences one RAM transaction at a time and returns ihit/dhit with load data.
// - Data has priority; a starvation counter guarantees instruction fetch progress.
// - A timeout watchdog flags a hung RAM.
// PARAMETERS
// - TIMEOUT     255  max cycles a grant may wait for ramstate==ACCESS before ERR (8-bit counter)
// - STARVE_MAX  4    consecutive data grants with iREN pending before one forced instr grant
// PORTS
// - CLK        in   1   clock, all state on rising edge
// - RST        in   1   synchronous, active-high reset
// - halt       in   1   datapath halted; iREN ignored while high
// - iREN       in   1   instruction read request
// - iaddr      in   32  instruction word address
// - dREN       in   1   data read request
// - dWEN       in   1   data write request (dREN&dWEN: write wins)
// - daddr      in   32  data address
// - dstore     in   32  data write value
// - ihit       out  1   instr access complete this cycle
// - iload      out  32  instr data, valid with ihit
// - dhit       out  1   data access complete this cycle
// - dload      out  32  data read value, valid with dhit
// - ramREN     out  1   RAM read strobe
// - ramWEN     out  1   RAM write strobe
// - ramaddr    out  32  RAM address
// - ramstore   out  32  RAM write data
// - ramload    in   32  RAM read data
// - ramstate   in   2   ramstate_t: FREE=0 BUSY=1 ACCESS=2 ERROR=3
// - err        out  1   sticky error (timeout or ramstate==ERROR); cleared only by RST
// BEHAVIOUR
// - Reset: state=IDLE, starve_cnt=0, wait_cnt=0, err=0; all outputs 0; RAM strobes low.
// - FSM states: IDLE, DGRANT, IGRANT, ERR.
//   - IDLE: (dREN|dWEN) and !(iREN&!halt&starve_cnt==STARVE_MAX) -> DGRANT.
//     Else if iREN&!halt -> IGRANT. Else stay.
//   - DGRANT drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN.
//   - IGRANT drives ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
//   - In xGRANT with ramstate==ACCESS, assert xhit combinationally the same cycle;
//     xload=ramload (dload=0 for writes); next state IDLE.
//   - In xGRANT with requester deasserted: abort, strobes low that cycle, next IDLE, no hit.
//   - In xGRANT with ramstate==ERROR, or wait_cnt==TIMEOUT: next ERR.
//   - ERR: err=1, strobes low, hits 0; exits only on RST.
// - Latency: 1 IDLE arbitration cycle + RAM wait states. Minimum request->hit is 2 cycles.
//   Back-to-back accesses always return through IDLE, so there is 1 bubble between them.
// - wait_cnt: cleared on entry to any GRANT; +1 each GRANT cycle with ramstate!=ACCESS;
//   saturates at TIMEOUT.
// - starve_cnt:
//   - +1 on each DGRANT completion with iREN&!halt high;
//   - cleared on IGRANT completion, or when iREN is low or halt is high in IDLE;
//   - saturates at STARVE_MAX.
// - Grant is held until completion or abort. A new request in mid-transaction waits.
// - RST mid-transaction: strobes drop the same cycle RST is sampled high; hits suppressed.
// - Only the granted side's hit may be high; ihit&dhit is never 1.
// STRUCTURE
// - cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t {IDLE,DGRANT,IGRANT,ERR}.
// - Single module. Next-state/output logic in always_comb, state regs in always_ff.
// - RAM mux is combinational from the registered state, so there is no extra latency.
// TESTING
// - Reset: RST=1 for 2 cycles with all requests high -> all outputs 0, state IDLE, err=0.
// - Instr read: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C220004
//   -> ramaddr=0x40 and ramREN=1 during IGRANT; ihit=1 for 1 cycle; iload=0x8C220004.
// - Priority: iREN and dREN both high in IDLE, daddr=0x100, ramload=0xDEADBEEF
//   -> DGRANT first with dhit, dload=0xDEADBEEF; then IDLE; then IGRANT.
// - Starvation: iREN held and 5 back-to-back dWEN requests, STARVE_MAX=4
//   -> 4 DGRANTs, then 1 IGRANT, then the 5th DGRANT.
// - Timeout: dREN=1 with ramstate stuck BUSY -> after 256 GRANT cycles state ERR, err=1,
//   strobes 0; err holds until RST.
// - Abort/halt: dREN dropped mid-DGRANT -> IDLE next cycle, no dhit.
//   With halt=1 and iREN=1 -> no IGRANT ever.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    ERR    = 2'd3
  } arb_state_t;

  localparam logic [7:0] TIMEOUT_DEF    = 8'd255;
  localparam logic [2:0] STARVE_MAX_DEF = 3'd4;

endpackage

// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access.
//
// state  | meaning
// IDLE   | arbitration cycle, no RAM strobes
// DGRANT | data side owns the RAM until hit, abort or error
// IGRANT | instruction side owns the RAM until hit, abort or error
// ERR    | RAM reported ERROR or a grant timed out; sticky until RST
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT    = TIMEOUT_DEF,
  parameter logic [2:0] STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      halt,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arb_state_t state, state_n;
  logic [7:0] wait_cnt;
  logic [2:0] starve_cnt;
  logic       dreq, ireq, in_grant;

  // halt masks instruction requests everywhere, including an open IGRANT
  assign dreq     = dREN | dWEN;
  assign ireq     = iREN & ~halt;
  assign in_grant = (state == DGRANT) || (state == IGRANT);
  assign err      = (state == ERR);

  // Next state and RAM mux; everything is forced idle while RST is high
  always_comb begin
    state_n  = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (dreq && !(ireq && (starve_cnt == STARVE_MAX))) state_n = DGRANT;
          else if (ireq)                                     state_n = IGRANT;
        end
        DGRANT: begin
          if (ramstate == ERROR) state_n = ERR;
          else if (!dreq)        state_n = IDLE;
          else begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ramstate == ACCESS) begin
              dhit    = 1'b1;
              dload   = dWEN ? '0 : ramload;
              state_n = IDLE;
            end else if (wait_cnt == TIMEOUT) begin
              state_n = ERR;
            end
          end
        end
        IGRANT: begin
          if (ramstate == ERROR) state_n = ERR;
          else if (!ireq)        state_n = IDLE;
          else begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (ramstate == ACCESS) begin
              ihit    = 1'b1;
              iload   = ramload;
              state_n = IDLE;
            end else if (wait_cnt == TIMEOUT) begin
              state_n = ERR;
            end
          end
        end
        default: state_n = ERR;
      endcase
    end
  end

  // State register, wait-state watchdog and starvation counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_n;

      if ((state == IDLE) && (state_n != IDLE))
        wait_cnt <= '0;
      else if (in_grant && (ramstate != ACCESS) && (wait_cnt != TIMEOUT))
        wait_cnt <= wait_cnt + 8'd1;

      if (dhit && ireq) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 3'd1;
      end else if (ihit) begin
        starve_cnt <= '0;
      end else if ((state == IDLE) && !ireq) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, fetch, priority, starvation,
// abort, halt, timeout, RAM error and reset during a grant.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic      CLK, RST, halt, iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      ihit, dhit, ramREN, ramWEN, err;
  word_t     iload, dload, ramaddr, ramstore;

  int tests  = 0;
  int failed = 0;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1ns later
  task automatic nxt();
    @(negedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1; halt = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h40; daddr = 32'h100; dstore = 32'hA5A5A5A5;
    ramload = 32'h11111111; ramstate = ACCESS;

    // Reset held two cycles with every request high
    nxt(); nxt(); settle();
    chk("rst_ramren", {31'b0, ramREN}, 32'd0);
    chk("rst_ramwen", {31'b0, ramWEN}, 32'd0);
    chk("rst_hits",   {30'b0, ihit, dhit}, 32'd0);
    chk("rst_err",    {31'b0, err}, 32'd0);
    chk("rst_addr",   ramaddr, 32'd0);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; RST = 1'b0; ramstate = FREE;
    nxt(); settle();
    chk("idle_err",    {31'b0, err}, 32'd0);
    chk("idle_ramren", {31'b0, ramREN}, 32'd0);

    // Instruction read with two wait states
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h8C220004; settle();
    chk("if_arb_ramren", {31'b0, ramREN}, 32'd0);
    nxt(); settle();
    chk("if_w1_addr",   ramaddr, 32'h40);
    chk("if_w1_ramren", {31'b0, ramREN}, 32'd1);
    chk("if_w1_ihit",   {31'b0, ihit}, 32'd0);
    nxt(); settle();
    chk("if_w2_ihit",   {31'b0, ihit}, 32'd0);
    nxt(); ramstate = ACCESS; settle();
    chk("if_ihit",  {31'b0, ihit}, 32'd1);
    chk("if_iload", iload, 32'h8C220004);
    chk("if_dhit",  {31'b0, dhit}, 32'd0);
    nxt(); iREN = 1'b0; ramstate = FREE; settle();
    chk("if_after_ihit", {31'b0, ihit}, 32'd0);
    chk("if_after_ren",  {31'b0, ramREN}, 32'd0);

    // Data beats instruction when both request in IDLE
    nxt(); iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = ACCESS; settle();
    chk("pri_arb_ren", {31'b0, ramREN}, 32'd0);
    nxt(); settle();
    chk("pri_d_addr",  ramaddr, 32'h100);
    chk("pri_d_hit",   {31'b0, dhit}, 32'd1);
    chk("pri_d_load",  dload, 32'hDEADBEEF);
    chk("pri_d_ihit",  {31'b0, ihit}, 32'd0);
    nxt(); dREN = 1'b0; settle();
    chk("pri_bubble_ren", {31'b0, ramREN}, 32'd0);
    chk("pri_bubble_hit", {30'b0, ihit, dhit}, 32'd0);
    nxt(); settle();
    chk("pri_i_addr", ramaddr, 32'h40);
    chk("pri_i_hit",  {31'b0, ihit}, 32'd1);
    chk("pri_i_load", iload, 32'hDEADBEEF);
    chk("pri_i_dhit", {31'b0, dhit}, 32'd0);
    nxt(); iREN = 1'b0; settle();

    // Starvation: iREN held through back-to-back writes
    nxt(); iREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678; ramstate = ACCESS; settle();
    for (int k = 0; k < 12; k++) begin
      if (k != 0) begin nxt(); settle(); end
      if (k % 2 == 0) begin
        chk($sformatf("stv%0d_idle_hits", k), {30'b0, ihit, dhit}, 32'd0);
        chk($sformatf("stv%0d_idle_wen", k), {31'b0, ramWEN}, 32'd0);
      end else if (k == 9) begin
        chk("stv9_i_addr", ramaddr, 32'h40);
        chk("stv9_i_hits", {30'b0, ihit, dhit}, 32'b10);
      end else begin
        chk($sformatf("stv%0d_d_addr", k), ramaddr, 32'h200);
        chk($sformatf("stv%0d_d_wen", k), {31'b0, ramWEN}, 32'd1);
        chk($sformatf("stv%0d_d_hits", k), {30'b0, ihit, dhit}, 32'b01);
        chk($sformatf("stv%0d_d_store", k), ramstore, 32'h12345678);
        chk($sformatf("stv%0d_d_load", k), dload, 32'd0);
      end
    end
    nxt(); iREN = 1'b0; dWEN = 1'b0; ramstate = FREE; settle();

    // Abort: dREN dropped during a wait state
    nxt(); dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; settle();
    nxt(); settle();
    chk("abt_grant_ren",  {31'b0, ramREN}, 32'd1);
    chk("abt_grant_addr", ramaddr, 32'h300);
    nxt(); dREN = 1'b0; settle();
    chk("abt_ren", {31'b0, ramREN}, 32'd0);
    chk("abt_hit", {31'b0, dhit}, 32'd0);
    nxt(); dREN = 1'b1; ramstate = ACCESS; ramload = 32'hCAFEF00D; settle();
    chk("abt_idle_hit", {31'b0, dhit}, 32'd0);
    chk("abt_idle_ren", {31'b0, ramREN}, 32'd0);
    nxt(); settle();
    chk("abt_retry_hit",  {31'b0, dhit}, 32'd1);
    chk("abt_retry_load", dload, 32'hCAFEF00D);
    nxt(); dREN = 1'b0; settle();

    // Halt masks instruction fetch
    halt = 1'b1; iREN = 1'b1; ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      nxt(); settle();
      chk($sformatf("halt%0d_ren", k), {31'b0, ramREN}, 32'd0);
      chk($sformatf("halt%0d_ihit", k), {31'b0, ihit}, 32'd0);
    end
    halt = 1'b0; iREN = 1'b0; ramstate = FREE;
    nxt(); settle();

    // Timeout: 256 grant cycles stuck in BUSY, then ERR
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY; settle();
    for (int k = 1; k <= 256; k++) begin
      nxt(); settle();
      if (k == 1 || k == 255 || k == 256) begin
        chk($sformatf("to_g%0d_ren", k), {31'b0, ramREN}, 32'd1);
        chk($sformatf("to_g%0d_err", k), {31'b0, err}, 32'd0);
      end
    end
    nxt(); settle();
    chk("to_err",     {31'b0, err}, 32'd1);
    chk("to_err_ren", {31'b0, ramREN}, 32'd0);
    ramstate = ACCESS; settle();
    chk("to_err_hit", {30'b0, ihit, dhit}, 32'd0);
    dREN = 1'b0; iREN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt(); settle();
      chk($sformatf("to_hold%0d_err", k), {31'b0, err}, 32'd1);
      chk($sformatf("to_hold%0d_ren", k), {31'b0, ramREN}, 32'd0);
    end
    iREN = 1'b0; RST = 1'b1;
    nxt(); RST = 1'b0; settle();
    chk("to_cleared_err", {31'b0, err}, 32'd0);

    // Reset during a grant drops strobes and suppresses the hit immediately
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY; settle();
    nxt(); settle();
    chk("rg_grant_ren", {31'b0, ramREN}, 32'd1);
    RST = 1'b1; ramstate = ACCESS; settle();
    chk("rg_ren", {31'b0, ramREN}, 32'd0);
    chk("rg_hit", {31'b0, dhit}, 32'd0);
    nxt(); RST = 1'b0; ramstate = BUSY; settle();
    chk("rg_idle_ren", {31'b0, ramREN}, 32'd0);

    // RAM ERROR during a grant
    nxt(); ramstate = ERROR; settle();
    chk("re_pre_err", {31'b0, err}, 32'd0);
    nxt(); dREN = 1'b0; settle();
    chk("re_err",     {31'b0, err}, 32'd1);
    chk("re_err_ren", {31'b0, ramREN}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
